// File: rtl/aes_round_ctrl_if.sv
// Request/status bundle between the AES round sequencer and whoever drives it.
interface aes_round_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    logic             start;
    logic             enc_dec;
    logic [1:0]       mode;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             op_dec;
    logic [3:0]       round;
    logic [CNT_W-1:0] sub_cnt;
    logic             key_gen;
    logic [3:0]       key_sched_round;
    logic             round_start;
    logic             round_complete;
    logic             done;
    logic             err;

    modport master (
        output start, enc_dec, mode, abort,
        input  ready, busy, op_dec, round, sub_cnt, key_gen, key_sched_round,
               round_start, round_complete, done, err
    );

    modport slave (
        input  start, enc_dec, mode, abort,
        output ready, busy, op_dec, round, sub_cnt, key_gen, key_sched_round,
               round_start, round_complete, done, err
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer: optional reverse key schedule, then
// rounds 0..Nr split into sub-cycles, with accept/busy, abort and mode checks.
module aes_round_ctrl #(
    parameter int unsigned SUB_ENC  = 16,
    parameter int unsigned SUB_DEC  = 20,
    parameter int unsigned SUB_INIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    aes_round_ctrl_if.slave   bus
);
    localparam int unsigned RND_W = 4;
    localparam logic [CNT_W-1:0] ENC_LAST  = CNT_W'(SUB_ENC - 1);
    localparam logic [CNT_W-1:0] DEC_LAST  = CNT_W'(SUB_DEC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SUB_INIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYGEN,
        ST_INIT,
        ST_ROUND,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [CNT_W-1:0]   sub_q, sub_d;
    logic [RND_W-1:0]   ksr_q, ksr_d;
    logic [1:0]         mode_q, mode_d;
    logic               op_dec_q, op_dec_d;
    logic               key_gen_q, key_gen_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [RND_W-1:0]   nr_c;
    logic [CNT_W-1:0]   sub_last_c;
    logic [CNT_W-1:0]   cur_last_c;
    logic               in_round_c;

    // Round count and per-round sub-cycle limit from the latched operation
    always_comb begin
        case (mode_q)
            2'b01:   nr_c = RND_W'(12);
            2'b10:   nr_c = RND_W'(14);
            default: nr_c = RND_W'(10);
        endcase
        sub_last_c = op_dec_q ? DEC_LAST : ENC_LAST;
        cur_last_c = (state_q == ST_INIT) ? INIT_LAST : sub_last_c;
        in_round_c = (state_q == ST_INIT) || (state_q == ST_ROUND);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            round_q   <= '0;
            sub_q     <= '0;
            ksr_q     <= '0;
            mode_q    <= '0;
            op_dec_q  <= 1'b0;
            key_gen_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            sub_q     <= sub_d;
            ksr_q     <= ksr_d;
            mode_q    <= mode_d;
            op_dec_q  <= op_dec_d;
            key_gen_q <= key_gen_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state sequencing; abort returns to IDLE from any active phase
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        sub_d     = sub_q;
        ksr_d     = ksr_q;
        mode_d    = mode_q;
        op_dec_d  = op_dec_q;
        key_gen_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.mode == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d   = bus.mode;
                        op_dec_d = bus.enc_dec;
                        sub_d    = '0;
                        if (bus.enc_dec) begin
                            state_d   = ST_KEYGEN;
                            round_d   = '0;
                            ksr_d     = '0;
                            key_gen_d = 1'b1;
                        end else begin
                            state_d = ST_ROUND;
                            round_d = RND_W'(1);
                        end
                    end
                end
            end
            ST_KEYGEN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    sub_d   = '0;
                end else if (ksr_q == nr_c) begin
                    state_d = ST_INIT;
                    round_d = '0;
                    sub_d   = '0;
                end else begin
                    ksr_d     = ksr_q + RND_W'(1);
                    key_gen_d = 1'b1;
                end
            end
            ST_INIT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    sub_d   = '0;
                end else if (sub_q == cur_last_c) begin
                    state_d = ST_ROUND;
                    round_d = RND_W'(1);
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + CNT_W'(1);
                end
            end
            ST_ROUND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    sub_d   = '0;
                end else if (sub_q == cur_last_c) begin
                    sub_d = '0;
                    if (round_q == nr_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + RND_W'(1);
                    end
                end else begin
                    sub_d = sub_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sub_d   = '0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    assign bus.ready           = ready_q;
    assign bus.busy            = busy_q;
    assign bus.op_dec          = op_dec_q;
    assign bus.round           = round_q;
    assign bus.sub_cnt         = sub_q;
    assign bus.key_gen         = key_gen_q;
    assign bus.key_sched_round = ksr_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;
    assign bus.round_start     = in_round_c && (sub_q == '0);
    assign bus.round_complete  = in_round_c && (sub_q == cur_last_c);
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboarded bench for the AES round sequencer (default and SUB=1 builds).
module tb_aes_round_ctrl;
    logic       clk;
    logic       reset;
    logic       start;
    logic       enc_dec;
    logic       abort;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] round;
        logic [4:0] sub;
        logic       rs;
        logic       rc;
        logic       kg;
        logic [3:0] ksr;
        logic       done;
        logic       ready;
        logic       busy;
        logic       err;
        logic       dec;
    } obs_t;

    typedef struct {
        int         lat;
        logic [3:0] rnd;
        logic       dec;
    } exp_t;

    exp_t sb[$];
    obs_t trace[$];
    obs_t obs0, obs1;

    aes_round_ctrl_if #(.CNT_W(5)) bus0();
    aes_round_ctrl_if #(.CNT_W(5)) bus1();

    assign bus0.start   = start;
    assign bus0.enc_dec = enc_dec;
    assign bus0.mode    = mode;
    assign bus0.abort   = abort;
    assign bus1.start   = start;
    assign bus1.enc_dec = enc_dec;
    assign bus1.mode    = mode;
    assign bus1.abort   = abort;

    aes_round_ctrl #(.SUB_ENC(16), .SUB_DEC(20), .SUB_INIT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    aes_round_ctrl #(.SUB_ENC(1), .SUB_DEC(3), .SUB_INIT(2), .CNT_W(5)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs0.round = bus0.round;          obs0.sub   = bus0.sub_cnt;
        obs0.rs    = bus0.round_start;    obs0.rc    = bus0.round_complete;
        obs0.kg    = bus0.key_gen;        obs0.ksr   = bus0.key_sched_round;
        obs0.done  = bus0.done;           obs0.ready = bus0.ready;
        obs0.busy  = bus0.busy;           obs0.err   = bus0.err;
        obs0.dec   = bus0.op_dec;
    end

    always_comb begin
        obs1.round = bus1.round;          obs1.sub   = bus1.sub_cnt;
        obs1.rs    = bus1.round_start;    obs1.rc    = bus1.round_complete;
        obs1.kg    = bus1.key_gen;        obs1.ksr   = bus1.key_sched_round;
        obs1.done  = bus1.done;           obs1.ready = bus1.ready;
        obs1.busy  = bus1.busy;           obs1.err   = bus1.err;
        obs1.dec   = bus1.op_dec;
    end

    function automatic obs_t sample(input bit which);
        return which ? obs1 : obs0;
    endfunction

    // Issue one request and record one observation per cycle until done (cycle n -> trace[n-1])
    task automatic run_op(input bit which, input logic [1:0] m, input logic ed,
                          input bit noise, input int budget, output int lat);
        obs_t o;
        trace.delete();
        lat = -1;
        @(posedge clk); #1;
        start = 1'b1; mode = m; enc_dec = ed;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            o = sample(which);
            trace.push_back(o);
            if (o.done) begin
                lat = n;
                start = 1'b0;
                break;
            end
            if (noise) begin
                start   = 1'($urandom);
                mode    = 2'($urandom);
                enc_dec = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        mode  = 2'b00;
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; enc_dec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        o = sample(1'b0);
        checks++;
        if ({o.ready, o.busy, o.round, o.sub, o.ksr, o.dec, o.done, o.err, o.kg}
            !== {1'b1, 1'b0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b rnd=%0d sub=%0d ksr=%0d dec=%b done=%b err=%b kg=%b want 1 0 0 0 0 0 0 0 0",
                     o.ready, o.busy, o.round, o.sub, o.ksr, o.dec, o.done, o.err, o.kg);
        end
        reset = 1'b0;
    endtask

    task automatic test_enc128();
        exp_t e; obs_t o; int lat; int rs_n; int rc_n; int k;
        logic [3:0] er; logic [4:0] es;
        rs_n = 0; rc_n = 0;
        sb.push_back('{lat: 161, rnd: 4'd10, dec: 1'b0});
        run_op(1'b0, 2'b00, 1'b0, 1'b0, 400, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL enc128_latency got %0d want %0d", lat, e.lat); end
        o = trace[trace.size() - 1];
        checks++;
        if ({o.round, o.dec} !== {e.rnd, e.dec}) begin
            errors++; $display("FAIL enc128_final got rnd=%0d dec=%b want rnd=%0d dec=%b", o.round, o.dec, e.rnd, e.dec);
        end
        for (int n = 1; n <= 160 && n <= trace.size(); n++) begin
            o = trace[n - 1];
            k = n - 1;
            er = 4'(k / 16 + 1);
            es = 5'(k % 16);
            rs_n += int'(o.rs);
            rc_n += int'(o.rc);
            checks++;
            if ({o.round, o.sub, o.rs, o.rc, o.kg, o.busy} !== {er, es, es == 5'd0, es == 5'd15, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL enc128_seq cyc %0d got rnd=%0d sub=%0d rs=%b rc=%b kg=%b busy=%b want rnd=%0d sub=%0d",
                         n, o.round, o.sub, o.rs, o.rc, o.kg, o.busy, er, es);
            end
        end
        checks++;
        if ({rs_n, rc_n} !== {32'sd10, 32'sd10}) begin
            errors++; $display("FAIL enc128_pulses got rs=%0d rc=%0d want 10 10", rs_n, rc_n);
        end
    endtask

    task automatic test_dec256();
        exp_t e; obs_t o; int lat; int kg_n; int rc_n; int k;
        logic [3:0] er; logic [4:0] es;
        kg_n = 0; rc_n = 0;
        sb.push_back('{lat: 312, rnd: 4'd14, dec: 1'b1});
        run_op(1'b0, 2'b10, 1'b1, 1'b0, 600, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL dec256_latency got %0d want %0d", lat, e.lat); end
        o = trace[trace.size() - 1];
        checks++;
        if ({o.round, o.dec} !== {e.rnd, e.dec}) begin
            errors++; $display("FAIL dec256_final got rnd=%0d dec=%b want rnd=%0d dec=%b", o.round, o.dec, e.rnd, e.dec);
        end
        for (int n = 1; n <= 311 && n <= trace.size(); n++) begin
            o = trace[n - 1];
            kg_n += int'(o.kg);
            rc_n += int'(o.rc);
            checks++;
            if (n <= 15) begin
                if ({o.kg, o.ksr, o.rs, o.rc} !== {1'b1, 4'(n - 1), 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL dec256_keygen cyc %0d got kg=%b ksr=%0d rs=%b rc=%b want kg=1 ksr=%0d", n, o.kg, o.ksr, o.rs, o.rc, n - 1);
                end
            end else begin
                if (n <= 31) begin
                    k = n - 16; er = 4'd0; es = 5'(k);
                end else begin
                    k = n - 32; er = 4'(k / 20 + 1); es = 5'(k % 20);
                end
                if ({o.kg, o.round, o.sub, o.rs, o.rc}
                    !== {1'b0, er, es, es == 5'd0, es == ((n <= 31) ? 5'd15 : 5'd19)}) begin
                    errors++;
                    $display("FAIL dec256_seq cyc %0d got kg=%b rnd=%0d sub=%0d rs=%b rc=%b want rnd=%0d sub=%0d",
                             n, o.kg, o.round, o.sub, o.rs, o.rc, er, es);
                end
            end
        end
        checks++;
        if ({kg_n, rc_n} !== {32'sd15, 32'sd15}) begin
            errors++; $display("FAIL dec256_pulses got kg=%0d rc=%0d want 15 15", kg_n, rc_n);
        end
    endtask

    task automatic test_sub1();
        exp_t e; obs_t o; int lat;
        sb.push_back('{lat: 13, rnd: 4'd12, dec: 1'b0});
        run_op(1'b1, 2'b01, 1'b0, 1'b0, 100, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL sub1_latency got %0d want %0d", lat, e.lat); end
        o = trace[trace.size() - 1];
        checks++;
        if (o.round !== e.rnd) begin errors++; $display("FAIL sub1_final got rnd=%0d want %0d", o.round, e.rnd); end
        for (int n = 1; n <= 12 && n <= trace.size(); n++) begin
            o = trace[n - 1];
            checks++;
            if ({o.round, o.sub, o.rs, o.rc} !== {4'(n), 5'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL sub1_seq cyc %0d got rnd=%0d sub=%0d rs=%b rc=%b want rnd=%0d sub=0 rs=1 rc=1", n, o.round, o.sub, o.rs, o.rc, n);
            end
        end
        // the default build accepted the same request; cancel it
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_illegal();
        obs_t o; logic [3:0] r0;
        @(posedge clk); #1;
        r0 = sample(1'b0).round;
        start = 1'b1; mode = 2'b11; enc_dec = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'b00;
        o = sample(1'b0);
        checks++;
        if ({o.err, o.ready, o.busy, o.kg} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL illegal_err got err=%b rdy=%b busy=%b kg=%b want 1 1 0 0", o.err, o.ready, o.busy, o.kg);
        end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            o = sample(1'b0);
            checks++;
            if ({o.err, o.ready, o.kg, o.round, o.sub} !== {1'b0, 1'b1, 1'b0, r0, 5'd0}) begin
                errors++;
                $display("FAIL illegal_after cyc %0d got err=%b rdy=%b kg=%b rnd=%0d sub=%0d want 0 1 0 %0d 0", n, o.err, o.ready, o.kg, o.round, o.sub, r0);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e; obs_t o; int lat; bit hit; int done_n; int rdy_bad;
        hit = 1'b0; done_n = 0; rdy_bad = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b00; enc_dec = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            o = sample(1'b0);
            if (o.round == 4'd5 && o.sub == 5'd7) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach got hit=%b want 1", hit); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        o = sample(1'b0);
        checks++;
        if ({o.ready, o.busy, o.sub, o.kg, o.done} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL abort_idle got rdy=%b busy=%b sub=%0d kg=%b done=%b want 1 0 0 0 0", o.ready, o.busy, o.sub, o.kg, o.done);
        end
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            o = sample(1'b0);
            done_n += int'(o.done);
            rdy_bad += int'(!o.ready);
        end
        checks++;
        if ({done_n, rdy_bad} !== {32'sd0, 32'sd0}) begin
            errors++; $display("FAIL abort_nodone got done=%0d notready=%0d want 0 0", done_n, rdy_bad);
        end
        sb.push_back('{lat: 193, rnd: 4'd12, dec: 1'b0});
        run_op(1'b0, 2'b01, 1'b0, 1'b0, 400, lat);
        e = sb.pop_front();
        o = trace[trace.size() - 1];
        checks++;
        if ({lat, o.round, o.dec} !== {e.lat, e.rnd, e.dec}) begin
            errors++; $display("FAIL abort_restart got lat=%0d rnd=%0d want lat=%0d rnd=%0d", lat, o.round, e.lat, e.rnd);
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e; obs_t o; int lat;
        sb.push_back('{lat: 161, rnd: 4'd10, dec: 1'b0});
        run_op(1'b0, 2'b00, 1'b0, 1'b1, 400, lat);
        e = sb.pop_front();
        o = trace[trace.size() - 1];
        checks++;
        if ({lat, o.round, o.dec} !== {e.lat, e.rnd, e.dec}) begin
            errors++; $display("FAIL busy_ignore got lat=%0d rnd=%0d dec=%b want lat=%0d rnd=%0d dec=%b", lat, o.round, o.dec, e.lat, e.rnd, e.dec);
        end
    endtask

    task automatic test_reset_keygen();
        obs_t o;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; mode = 2'b00; enc_dec = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        o = sample(1'b0);
        checks++;
        if ({o.kg, o.ksr, o.dec} !== {1'b1, 4'd4, 1'b1}) begin
            errors++; $display("FAIL keygen_mid got kg=%b ksr=%0d dec=%b want 1 4 1", o.kg, o.ksr, o.dec);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        o = sample(1'b0);
        checks++;
        if ({o.ready, o.busy, o.round, o.sub, o.ksr, o.dec, o.done, o.err, o.kg}
            !== {1'b1, 1'b0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL keygen_reset got rdy=%b busy=%b rnd=%0d sub=%0d ksr=%0d dec=%b done=%b err=%b kg=%b want 1 0 0 0 0 0 0 0 0",
                     o.ready, o.busy, o.round, o.sub, o.ksr, o.dec, o.done, o.err, o.kg);
        end
    endtask

    initial begin
        test_reset();
        test_enc128();
        test_dec256();
        test_sub1();
        test_illegal();
        test_abort();
        test_busy_ignore();
        test_reset_keygen();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
